// File: rtl/clk_en_gen_pkg.sv
// clk_en_pkg: shared types and constants for the fractional clock-enable generator.
// FSM state encoding, 48 MHz default increments and the channel-index width helper.
package clk_en_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        RELOCK = 2'd2
    } state_e;

    // Increments for a 48 MHz refclk with a 16-bit accumulator
    localparam logic [15:0] INC_24M = 16'h8000;
    localparam logic [15:0] INC_12M = 16'h4000;
    localparam logic [15:0] INC_6M  = 16'h2000;

    // Channel 0 in the LSBs: 24, 12 and 6 MHz
    localparam logic [47:0] DEFAULT_INC_48M = {INC_6M, INC_12M, INC_24M};

    // Width of the channel select field; never narrower than one bit
    function automatic int ch_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// clk_en_gen_if: runtime reconfiguration handshake for clk_en_gen.
// master drives a request (channel, increment, phase); slave answers with ready.
interface clk_en_gen_if
    import clk_en_pkg::*;
#(
    parameter int NUM_CLOCKS = 3,
    parameter int ACC_W      = 16
);
    localparam int CH_W = ch_width(NUM_CLOCKS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic [ACC_W-1:0] cfg_phase;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_inc,
        output cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_inc,
        input  cfg_phase,
        output cfg_ready
    );

endinterface

// File: rtl/clk_en_gen_chan.sv
// clk_en_chan: one phase-accumulator channel of clk_en_gen.
// Holds inc/phase, reloads the accumulator from phase while not running and
// registers the accumulator carry as a single-cycle enable strobe.
// Optional square output under CLKEN_SQUARE_EN.
module clk_en_chan #(
    parameter int               ACC_W   = 16,
    parameter logic [ACC_W-1:0] RST_INC = 16'h8000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,        // FSM is in RUN this cycle
    input  logic             strobe_en_i,  // RUN this cycle and the next
    input  logic             wr_en_i,      // accepted write to this channel
    input  logic [ACC_W-1:0] wr_inc_i,
    input  logic [ACC_W-1:0] wr_phase_i,
`ifdef CLKEN_SQUARE_EN
    input  logic             sq_en_i,      // locked in the next cycle
    output logic             outclk_o,
`endif
    output logic             ce_o
);

    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] phase_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic             ce_q;

    // Accumulator next state: advance while running, otherwise park at the phase offset
    always_comb begin
        sum_s   = {1'b0, acc_q} + {1'b0, inc_q};
        carry_s = sum_s[ACC_W];
        if (run_i) begin
            acc_d = sum_s[ACC_W-1:0];
        end else begin
            acc_d = phase_q;
        end
    end

    // Channel registers: accumulator, strobe and runtime-programmable inc/phase
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inc_q   <= RST_INC;
            phase_q <= {ACC_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            ce_q    <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= strobe_en_i & carry_s;
            if (wr_en_i) begin
                inc_q   <= wr_inc_i;
                phase_q <= wr_phase_i;
            end else begin
                inc_q   <= inc_q;
                phase_q <= phase_q;
            end
        end
    end

    assign ce_o = ce_q;

`ifdef CLKEN_SQUARE_EN
    logic outclk_q;

    // Square output follows the accumulator MSB while locked, low otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outclk_q <= 1'b0;
        end else begin
            outclk_q <= sq_en_i & acc_d[ACC_W-1];
        end
    end

    assign outclk_o = outclk_q;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: parametrised fractional clock-enable generator.
// FSM (HOLD/RUN/RELOCK), hold-off counter and cfg decode; NUM_CLOCKS
// clk_en_chan instances produce the strobes. After reset or any accepted
// reconfiguration every channel restarts from its phase behind `locked`.
// Optional feature macro: CLKEN_SQUARE_EN adds the `outclk` square outputs.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                          NUM_CLOCKS  = 3,
    parameter int                          ACC_W       = 16,
    parameter int                          LOCK_CYCLES = 64,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] DEFAULT_INC = DEFAULT_INC_48M
) (
    input  logic                  refclk,
    input  logic                  rst,
    clk_en_gen_if.slave           cfg,
    output logic [NUM_CLOCKS-1:0] ce_out,
`ifdef CLKEN_SQUARE_EN
    output logic [NUM_CLOCKS-1:0] outclk,
`endif
    output logic                  locked
);

    localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    locked_q;

    logic                    run_s;
    logic                    xfer_s;
    logic                    ch_ok_s;
    logic                    relock_go_s;
    logic                    run_next_s;
    logic                    strobe_en_s;
    logic [NUM_CLOCKS-1:0]   wr_en_s;

    // Handshake decode: a transfer to a valid channel triggers a write and a relock
    always_comb begin
        run_s       = (state_q == RUN);
        xfer_s      = cfg.cfg_valid & locked_q;
        ch_ok_s     = (int'(cfg.cfg_ch) < NUM_CLOCKS);
        relock_go_s = xfer_s & ch_ok_s;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            wr_en_s[i] = relock_go_s && (int'(cfg.cfg_ch) == i);
        end
        if (run_s) begin
            run_next_s = ~relock_go_s;
        end else if (state_q == HOLD || state_q == RELOCK) begin
            run_next_s = (cnt_q == CNT_LAST);
        end else begin
            run_next_s = 1'b0;
        end
        strobe_en_s = run_s & run_next_s;
    end

    // Control FSM with hold-off counter; locked (= cfg_ready) registered from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= HOLD;
            cnt_q    <= {CNT_W{1'b0}};
            locked_q <= 1'b0;
        end else begin
            locked_q <= run_next_s;
            case (state_q)
                HOLD, RELOCK: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= {CNT_W{1'b0}};
                    end else begin
                        state_q <= state_q;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (relock_go_s) begin
                        state_q <= RELOCK;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= HOLD;
                    cnt_q   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign locked        = locked_q;
    assign cfg.cfg_ready = locked_q;

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        clk_en_chan #(
            .ACC_W   (ACC_W),
            .RST_INC (DEFAULT_INC[g*ACC_W +: ACC_W])
        ) u_chan (
            .clk_i       (refclk),
            .rst_i       (rst),
            .run_i       (run_s),
            .strobe_en_i (strobe_en_s),
            .wr_en_i     (wr_en_s[g]),
            .wr_inc_i    (cfg.cfg_inc),
            .wr_phase_i  (cfg.cfg_phase),
`ifdef CLKEN_SQUARE_EN
            .sq_en_i     (run_next_s),
            .outclk_o    (outclk[g]),
`endif
            .ce_o        (ce_out[g])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: scoreboard bench for clk_en_gen (3 channels, 16-bit, 64-cycle lock).
// The stimulus side tracks the programmed inc/phase and the RUN start edge,
// pushes the expected {locked, ce_out} for every cycle; a negedge monitor
// pops and compares against the DUT.
module tb_clk_en_gen;
    import clk_en_pkg::*;

    localparam int NCH  = 3;
    localparam int LOCK = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] ce_out;
    logic           locked;
`ifdef CLKEN_SQUARE_EN
    logic [NCH-1:0] outclk;
`endif

    clk_en_gen_if #(.NUM_CLOCKS(NCH), .ACC_W(16)) ifc ();

    clk_en_gen dut (
        .refclk (clk),
        .rst    (rst),
        .cfg    (ifc.slave),
        .ce_out (ce_out),
`ifdef CLKEN_SQUARE_EN
        .outclk (outclk),
`endif
        .locked (locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // expected {locked, ce_out[2:0]} per cycle
    logic [3:0] exp_q[$];

    // bench-side view of the configuration
    int mI[NCH];
    int mP[NCH];
    int r_edge   = 1000000;  // edge after which RUN begins
    int k_edge   = -1;       // index of the most recent clock edge
    bit accepted = 1'b0;

    function automatic logic exp_ce(input int inc, input int ph, input int m);
        longint a;
        longint b;
        a = longint'(ph) + longint'(m) * longint'(inc);
        b = a - longint'(inc);
        return ((a >>> 16) != (b >>> 16));
    endfunction

    task automatic tick();
        logic [3:0] e;
        int m;
        @(posedge clk);
        k_edge   = k_edge + 1;
        accepted = 1'b0;
        if (rst) begin
            mI[0] = 32'h8000; mI[1] = 32'h4000; mI[2] = 32'h2000;
            for (int i = 0; i < NCH; i++) mP[i] = 0;
            r_edge = k_edge + LOCK;
        end else if (ifc.cfg_valid && (k_edge - 1 >= r_edge)) begin
            accepted = 1'b1;
            if (int'(ifc.cfg_ch) < NCH) begin
                mI[ifc.cfg_ch] = int'(ifc.cfg_inc);
                mP[ifc.cfg_ch] = int'(ifc.cfg_phase);
                r_edge = k_edge + LOCK;
            end
        end
        #1;
        e = 4'b0000;
        if (k_edge >= r_edge) begin
            e[3] = 1'b1;
            m = k_edge - r_edge;
            for (int i = 0; i < NCH; i++) begin
                if (m >= 1) e[i] = exp_ce(mI[i], mP[i], m);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_send(input logic [1:0] ch, input logic [15:0] inc, input logic [15:0] ph);
        bit done;
        done = 1'b0;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_ch    = ch;
        ifc.cfg_inc   = inc;
        ifc.cfg_phase = ph;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            done = accepted;
        end
        ifc.cfg_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL cfg_accept ch=%0d: actual=not accepted required=accepted within 300 cycles", ch);
        end
    endtask

    // Monitor: pop the expected response for this cycle and compare mid-cycle
    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (locked !== e[3]) begin
                n_fail++;
                $display("FAIL locked edge=%0d: actual=%b required=%b", k_edge, locked, e[3]);
            end
            n_checks++;
            if (ifc.cfg_ready !== e[3]) begin
                n_fail++;
                $display("FAIL cfg_ready edge=%0d: actual=%b required=%b", k_edge, ifc.cfg_ready, e[3]);
            end
            n_checks++;
            if (ce_out !== e[2:0]) begin
                n_fail++;
                $display("FAIL ce_out edge=%0d: actual=%b required=%b", k_edge, ce_out, e[2:0]);
            end
        end
    end

    initial begin
        ifc.cfg_valid = 1'b0;
        ifc.cfg_ch    = 2'd0;
        ifc.cfg_inc   = 16'h0000;
        ifc.cfg_phase = 16'h0000;
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        // reset release with defaults: locked at cycle 64, strobes every 2/4/8
        run(110);
        // ch1 -> 1/3 rate
        cfg_send(2'd1, 16'h5555, 16'h0000);
        run(130);
        // ch2 phase offset: first strobe one cycle after RUN, then every 8
        cfg_send(2'd2, 16'h2000, 16'hE000);
        run(100);
        // out-of-range channel: accepted, no relock, pattern unchanged
        cfg_send(2'd3, 16'h1234, 16'h4321);
        run(40);
        // disable ch0
        cfg_send(2'd0, 16'h0000, 16'h0000);
        run(100);
        // second request held through RELOCK is taken exactly once
        cfg_send(2'd1, 16'h4000, 16'h0000);
        cfg_send(2'd2, 16'h1000, 16'h0800);
        run(90);
        // reset in the middle of RELOCK restores defaults
        cfg_send(2'd1, 16'h5555, 16'h1111);
        run(20);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(110);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Parametrised fractional clock-enable generator, the successor to the fixed three-output PLL wrapper. It runs from the single PLL system clock and produces NUM_CLOCKS single-cycle enable strobes. Each strobe's average rate is set by a phase-accumulator increment that can be reprogrammed at runtime. After reset or any reconfiguration, all channels restart phase-aligned behind a `locked` indication, so video, CPU and audio logic share one clock domain.

## Interface
- NUM_CLOCKS, 3: number of enable channels (1..18).
- ACC_W, 16: accumulator and increment width.
- LOCK_CYCLES, 64: hold-off cycles before `locked` asserts, after reset and after each reconfiguration (≥1).
- DEFAULT_INC, {16'h2000,16'h4000,16'h8000}: packed NUM_CLOCKS×ACC_W reset increments; channel 0 is in the LSBs.
  - At 48 MHz these give 24, 12 and 6 MHz enables.
- refclk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  high when a request can be accepted.
- cfg_ch  in  $clog2(NUM_CLOCKS) (min 1)  target channel.
- cfg_inc  in  ACC_W  new increment; 0 disables the channel.
- cfg_phase  in  ACC_W  new accumulator start value (phase offset).
- ce_out  out  NUM_CLOCKS  registered enable strobes.
- locked  out  1  enables are valid and aligned.

## Operation
- FSM states: HOLD, RUN, RELOCK.
  - Reset enters HOLD.
  - HOLD → RUN when the hold counter reaches LOCK_CYCLES−1.
  - RUN → RELOCK on an accepted request with a valid channel.
  - RELOCK → RUN after LOCK_CYCLES cycles.
- Per-channel registers:
  - inc_i: reset value is DEFAULT_INC slice i.
  - phase_i: reset value is 0.
  - acc_i.
- HOLD and RELOCK behaviour:
  - acc_i is loaded with phase_i every cycle.
  - ce_out = 0, locked = 0, cfg_ready = 0.
- RUN behaviour:
  - acc_i ← (acc_i + inc_i) mod 2^ACC_W.
  - carry_i = carry-out of that ACC_W-bit sum.
  - ce_out[i] ← carry_i, registered.
  - locked = 1, cfg_ready = 1.
- Handshake:
  - A transfer occurs when cfg_valid & cfg_ready on a clock edge.
  - On transfer, inc/phase of cfg_ch are written, and the FSM enters RELOCK on the next cycle.
  - cfg_valid held while not ready is neither lost nor double-accepted.
- If cfg_ch ≥ NUM_CLOCKS: the transfer is accepted (cfg_ready stays 1), nothing is written, and there is no RELOCK.
- An inc_i of 0 means ce_out[i] is never asserted.
- A channel's average strobe rate is refclk·inc_i/2^ACC_W; the strobe period jitters by at most 1 cycle.
- rst high in any state, including mid-RELOCK:
  - Next state is HOLD.
  - All registers return to reset values; a pending cfg write is discarded.
- Reset values of outputs: ce_out = 0, locked = 0, cfg_ready = 0.

## Timing
- Define cycle 0 as the first clock edge with rst low. locked rises after edge LOCK_CYCLES−1 (first RUN cycle, T).
- At RUN cycle n (n = 0 at T): acc = P + n·I mod 2^ACC_W. ce_out[i] is high in cycle n+1 iff adding I to acc_n carries.
- ce_out is therefore guaranteed 0 in cycle T and valid from T+1.
- Request accepted at edge E:
  - locked and cfg_ready are low from the cycle after E.
  - ce_out is low from E+1.
  - RUN resumes LOCK_CYCLES cycles later with every accumulator reloaded from its phase, so all channels are realigned.
- Channels not targeted keep their inc/phase but are realigned too.

## Configuration
- Macro CLKEN_SQUARE_EN.
  - Defined: adds output `outclk`, NUM_CLOCKS wide, registered.
    - outclk[i] = MSB of acc_i while locked, else 0.
    - This gives an approximately 50 % duty square wave, for clock-out pins and scope debug.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package clk_en_pkg holds:
  - state enum (HOLD, RUN, RELOCK);
  - default increment constants for 48 MHz (24/12/6 MHz);
  - a helper function returning the channel-index width.
- Sub-module clk_en_chan:
  - one accumulator, its inc/phase registers, and the carry/strobe (and square) output;
  - instantiated NUM_CLOCKS times via generate.
- The top level holds the FSM, the hold counter and the cfg decode.

## Test plan
- Reset release with defaults, LOCK_CYCLES=64:
  - locked rises at cycle 64;
  - ce_out[0] strobes every 2nd cycle, ce_out[1] every 4th, ce_out[2] every 8th;
  - first strobes at T+2, T+4 and T+8 respectively.
- Program ch1 with inc=16'h5555, phase=0:
  - locked drops the cycle after the accept and returns 64 cycles later;
  - ch1 then strobes 1 per 3 cycles, i.e. 21845 strobes per 65536 cycles.
- Program ch2 with inc=16'h2000, phase=16'hE000: first ch2 strobe at T+1, then every 8 cycles.
- cfg_ch=3 with NUM_CLOCKS=3: accepted, locked stays 1, strobe pattern unchanged.
- cfg_inc=0: the channel never strobes while the others continue.
- rst asserted mid-RELOCK, then released: locked rises 64 cycles later with default increments restored.
